// File: rtl/serial_loader.sv
// Serial-to-parallel front end for an N-bit load-enable register: gathers an
// LSB-first bit stream, optionally checks one parity bit, then strobes the word out.
module serial_loader #(
  parameter int N         = 8,
  parameter bit PARITY_EN = 1'b1,
  parameter bit ODD       = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic         sin_vld,
  input  logic         sin,
  output logic [N-1:0] d_o,
  output logic         en_o,
  output logic         busy,
  output logic         err
);

  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_PAR   = 2'd2;
  localparam logic [1:0] S_LOAD  = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_shreg;
  logic [N-1:0]  r_d;
  logic          r_en;
  logic          r_err;

  logic [1:0]    w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [N-1:0]  w_shreg_nxt;
  logic          w_load;
  logic          w_err_nxt;
  logic          w_last_bit;
  logic          w_pcalc;

  function automatic logic f_parity(input logic [N-1:0] data, input logic odd);
    f_parity = (^data) ^ odd;
  endfunction

  function automatic logic [N-1:0] f_insert(input logic [N-1:0] word,
                                            input logic [CW-1:0] pos,
                                            input logic bit_in);
    f_insert = word;
    for (int i = 0; i < N; i++) begin
      if (pos == CW'(i)) f_insert[i] = bit_in;
    end
  endfunction

  assign w_last_bit = (r_cnt == CW'(N - 1));
  assign w_pcalc    = f_parity(r_shreg, ODD);

  // Next-state logic; abort outranks sin_vld and start in every busy state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shreg_nxt = r_shreg;
    w_load      = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // The cycle carrying the load strobe is still part of the previous frame.
        if (start && !abort && !r_en) begin
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = '0;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (sin_vld) begin
          w_shreg_nxt = f_insert(r_shreg, r_cnt, sin);
          w_cnt_nxt   = r_cnt + CW'(1);
          if (w_last_bit) w_state_nxt = PARITY_EN ? S_PAR : S_LOAD;
        end
      end
      S_PAR: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (sin_vld) begin
          if (sin == w_pcalc) begin
            w_state_nxt = S_LOAD;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_LOAD: begin
        w_state_nxt = S_IDLE;
        w_load      = !abort;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
      r_d     <= '0;
      r_en    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shreg <= w_shreg_nxt;
      r_en    <= w_load;
      r_err   <= w_err_nxt;
      if (w_load) r_d <= r_shreg;
    end
  end

  assign d_o  = r_d;
  assign en_o = r_en;
  assign err  = r_err;
  assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_loader.sv
// Directed bench for serial_loader: stimulus queues expected load/error events,
// per-DUT monitors pop and compare them as the outputs fire.
module tb_serial_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start1, start2, abort, sin_vld, sin;
  logic [7:0] d1, d2;
  logic       en1, en2, busy1, busy2, err1, err2;

  serial_loader #(.N(8), .PARITY_EN(1'b1), .ODD(1'b0)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort), .sin_vld(sin_vld), .sin(sin),
    .d_o(d1), .en_o(en1), .busy(busy1), .err(err1));

  serial_loader #(.N(8), .PARITY_EN(1'b0), .ODD(1'b1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort), .sin_vld(sin_vld), .sin(sin),
    .d_o(d2), .en_o(en2), .busy(busy2), .err(err2));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] d;
    int         cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_ev(input bit which, input bit is_err, input logic [7:0] d, input int c);
    exp_t e;
    e.is_err = is_err;
    e.d      = d;
    e.cyc    = c;
    if (which) q2.push_back(e);
    else q1.push_back(e);
  endtask

  logic [7:0] last1, last2;
  logic       pen1, pen2;

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst) begin
      last1 = 8'h00;
      pen1  = 1'b0;
    end else begin
      if (pen1) chk("dut1_busy_after_en", busy1, 0);
      if (en1) begin
        chk("dut1_err_with_en", err1, 0);
        chk("dut1_en_back_to_back", pen1, 0);
      end
      if (en1 || err1) begin
        if (q1.size() == 0) chk("dut1_unexpected_event", {en1, err1}, 0);
        else begin
          e = q1.pop_front();
          chk("dut1_event_kind_err", err1, e.is_err);
          chk("dut1_event_cycle", cyc, e.cyc);
          if (!e.is_err) chk("dut1_d_o", d1, e.d);
        end
      end
      if (!en1) chk("dut1_d_o_hold", d1, last1);
      else last1 = d1;
      pen1 = en1;
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (rst) begin
      last2 = 8'h00;
      pen2  = 1'b0;
    end else begin
      if (en2) chk("dut2_en_back_to_back", pen2, 0);
      if (err2) chk("dut2_err_without_parity", err2, 0);
      if (en2) begin
        if (q2.size() == 0) chk("dut2_unexpected_en", en2, 0);
        else begin
          e = q2.pop_front();
          chk("dut2_event_cycle", cyc, e.cyc);
          chk("dut2_d_o", d2, e.d);
        end
      end
      if (!en2) chk("dut2_d_o_hold", d2, last2);
      else last2 = d2;
      pen2 = en2;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input bit which, output int c0);
    if (which) start2 = 1'b1;
    else start1 = 1'b1;
    tick();
    start1 = 1'b0;
    start2 = 1'b0;
    c0 = cyc;
  endtask

  task automatic send(input logic b);
    sin     = b;
    sin_vld = 1'b1;
    tick();
    sin_vld = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] v, input int from, input int to);
    for (int i = from; i < to; i++) send(v[i]);
  endtask

  // Even-parity frame for 8'h03: bits 1,1,0,0,0,0,0,0 then parity 0.
  task automatic frame_03();
    int c0;
    go(1'b0, c0);
    expect_ev(1'b0, 1'b0, 8'h03, c0 + 10);
    send_bits(8'h03, 0, 8);
    send(1'b0);
    repeat (3) tick();
  endtask

  initial begin
    int c0;
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; abort = 1'b0; sin_vld = 1'b0; sin = 1'b0;
    repeat (2) tick();
    chk("reset_d_o", d1, 8'h00);
    chk("reset_en_o", en1, 0);
    chk("reset_busy", busy1, 0);
    chk("reset_err", err1, 0);
    rst = 1'b0;
    tick();

    frame_03();

    // Reset three bits into a frame: outputs clear without waiting for a clock.
    go(1'b0, c0);
    send_bits(8'h05, 0, 3);
    chk("midframe_busy_before_rst", busy1, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_d_o", d1, 8'h00);
    chk("async_rst_en_o", en1, 0);
    chk("async_rst_busy", busy1, 0);
    chk("async_rst_err", err1, 0);
    tick();
    rst = 1'b0;
    tick();

    frame_03();

    // 8'h0A has two ones: even parity is 0, so parity bit 1 must be rejected.
    go(1'b0, c0);
    expect_ev(1'b0, 1'b1, 8'h00, c0 + 9);
    send_bits(8'h0A, 0, 8);
    send(1'b1);
    repeat (3) tick();
    chk("parity_fail_d_o_kept", d1, 8'h03);
    chk("parity_fail_idle", busy1, 0);

    // Three stall cycles between bit 4 and bit 5 push the strobe out by three.
    go(1'b0, c0);
    expect_ev(1'b0, 1'b0, 8'h0A, c0 + 13);
    send_bits(8'h0A, 0, 4);
    sin_vld = 1'b0;
    repeat (3) tick();
    send_bits(8'h0A, 4, 8);
    send(1'b0);
    repeat (3) tick();

    // Abort after five bits (start pulsed mid-frame), then a clean 8'h55 frame.
    go(1'b0, c0);
    send_bits(8'hE7, 0, 2);
    start1 = 1'b1;
    send_bits(8'hE7, 2, 5);
    start1 = 1'b0;
    abort = 1'b1; sin = 1'b1; sin_vld = 1'b1;
    tick();
    abort = 1'b0; sin_vld = 1'b0;
    chk("abort_busy", busy1, 0);
    repeat (3) tick();
    chk("abort_d_o_kept", d1, 8'h0A);
    go(1'b0, c0);
    expect_ev(1'b0, 1'b0, 8'h55, c0 + 10);
    send_bits(8'h55, 0, 8);
    send(1'b0);
    repeat (3) tick();

    // No-parity build: strobe follows the 8th bit directly.
    go(1'b1, c0);
    expect_ev(1'b1, 1'b0, 8'hFF, c0 + 9);
    send_bits(8'hFF, 0, 8);
    repeat (4) tick();
    chk("nopar_busy_done", busy2, 0);

    for (int i = 0; i < 20 && (q1.size() != 0 || q2.size() != 0); i++) tick();
    chk("dut1_events_outstanding", q1.size(), 0);
    chk("dut2_events_outstanding", q2.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
